// File: rtl/fetch_issue_queue.sv
// ============================================================================
// Module      : fetch_issue_queue
// Description : Dual-wide fetch-to-decode instruction buffer. Fetch pairs go in,
//               and up to two of the oldest instructions are issued in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_issue_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [WIDTH-1:0]         instrf,
    input  logic [WIDTH-1:0]         instrf2,
    input  logic [WIDTH-1:0]         pcf,
    input  logic                     flush,
    input  logic [1:0]               issue_req,
    output logic [WIDTH-1:0]         instrd,
    output logic [WIDTH-1:0]         pcd,
    output logic [WIDTH-1:0]         instrd2,
    output logic [WIDTH-1:0]         pcd2,
    output logic                     validd,
    output logic                     validd2,
    output logic                     stallf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                    c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]         c_STALL_LVL = (c_AW+1)'(DEPTH - 2);
    localparam logic [c_AW:0]         c_TWO       = (c_AW+1)'(2);
    localparam logic [WIDTH-1:0]      c_PC_STEP   = WIDTH'(4);

    logic [WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [WIDTH-1:0] r_instr_mem [DEPTH];
    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_AW:0]    r_count;

    logic             w_enq;
    logic [1:0]       w_req;
    logic [1:0]       w_n;
    logic [c_AW-1:0]  w_head1;
    logic [c_AW-1:0]  w_tail1;

    // Stall only looks at the registered count, so issue_req never reaches stallf.
    assign stallf  = (r_count > c_STALL_LVL);
    assign w_enq   = fetch_valid & ~stallf & ~flush;
    assign w_head1 = r_head + 1'b1;
    assign w_tail1 = r_tail + 1'b1;

    always_comb begin
        w_req = (issue_req == 2'd3) ? 2'd2 : issue_req;
        w_n   = w_req;
        if (r_count == '0) begin
            w_n = 2'd0;
        end else if (r_count == (c_AW+1)'(1) && w_req != 2'd0) begin
            w_n = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_AW'(w_n);
            r_tail  <= w_enq ? (r_tail + c_AW'(2)) : r_tail;
            r_count <= r_count + (w_enq ? c_TWO : '0) - (c_AW+1)'(w_n);
        end
    end

    // Storage needs no reset; lanes are masked by count.
    always_ff @(posedge clk) begin
        if (w_enq && !reset) begin
            r_pc_mem[r_tail]     <= pcf;
            r_instr_mem[r_tail]  <= instrf;
            r_pc_mem[w_tail1]    <= pcf + c_PC_STEP;
            r_instr_mem[w_tail1] <= instrf2;
        end
    end

    assign validd  = (r_count != '0);
    assign validd2 = (r_count >= c_TWO);
    assign instrd  = validd  ? r_instr_mem[r_head]  : '0;
    assign pcd     = validd  ? r_pc_mem[r_head]     : '0;
    assign instrd2 = validd2 ? r_instr_mem[w_head1] : '0;
    assign pcd2    = validd2 ? r_pc_mem[w_head1]    : '0;
    assign count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_issue_queue.sv
// ============================================================================
// Module      : tb_fetch_issue_queue
// Description : Directed self-checking bench for fetch_issue_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] instrf;
    logic [31:0] instrf2;
    logic [31:0] pcf;
    logic        flush;
    logic [1:0]  issue_req;
    logic [31:0] instrd;
    logic [31:0] pcd;
    logic [31:0] instrd2;
    logic [31:0] pcd2;
    logic        validd;
    logic        validd2;
    logic        stallf;
    logic [3:0]  count;

    int passed = 0;
    int total  = 0;

    fetch_issue_queue #(.DEPTH(8), .WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .instrf      (instrf),
        .instrf2     (instrf2),
        .pcf         (pcf),
        .flush       (flush),
        .issue_req   (issue_req),
        .instrd      (instrd),
        .pcd         (pcd),
        .instrd2     (instrd2),
        .pcd2        (pcd2),
        .validd      (validd),
        .validd2     (validd2),
        .stallf      (stallf),
        .count       (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            assert (count <= 4'd8) else $error("FAIL count_bound count=%0d required<=8", count);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        issue_req   = 2'd0;
        reset       = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc);
        fetch_valid = 1'b1;
        pcf         = pc;
        instrf      = 32'hC000_0000 | pc;
        instrf2     = 32'hC000_0000 | (pc + 32'd4);
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({validd, validd2, stallf} !== 3'b000)
            $display("FAIL reset_flags got=%b required=000", {validd, validd2, stallf});
        else passed++;
        total++;
        if (count !== 4'd0) $display("FAIL reset_count got=%0d required=0", count);
        else passed++;
        total++;
        if ({instrd, pcd, instrd2, pcd2} !== 128'd0)
            $display("FAIL reset_data got=%h required=0", {instrd, pcd, instrd2, pcd2});
        else passed++;
    endtask

    task automatic test_single_pair;
        idle();
        fetch_valid = 1'b1;
        pcf         = 32'h100;
        instrf      = 32'hAAAA0001;
        instrf2     = 32'hBBBB0002;
        tick();
        fetch_valid = 1'b0;
        total++;
        if ({validd, validd2} !== 2'b11) $display("FAIL single_valid got=%b required=11", {validd, validd2});
        else passed++;
        total++;
        if (pcd !== 32'h100 || pcd2 !== 32'h104)
            $display("FAIL single_pc got=%h/%h required=100/104", pcd, pcd2);
        else passed++;
        total++;
        if (instrd !== 32'hAAAA0001 || instrd2 !== 32'hBBBB0002)
            $display("FAIL single_instr got=%h/%h required=aaaa0001/bbbb0002", instrd, instrd2);
        else passed++;
        total++;
        if (count !== 4'd2) $display("FAIL single_count got=%0d required=2", count);
        else passed++;
        issue_req = 2'd2;
        tick();
        issue_req = 2'd0;
        total++;
        if (count !== 4'd0 || validd !== 1'b0 || instrd !== 32'd0)
            $display("FAIL single_drain got count=%0d validd=%b instrd=%h required 0/0/0", count, validd, instrd);
        else passed++;
    endtask

    task automatic test_partial_issue;
        idle();
        push(32'h0);
        tick();
        push(32'h8);
        tick();
        fetch_valid = 1'b0;
        issue_req   = 2'd1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (pcd !== 32'(4 * k) || instrd !== (32'hC000_0000 | 32'(4 * k)))
                $display("FAIL partial_pcd[%0d] got=%h required=%h", k, pcd, 32'(4 * k));
            else passed++;
            total++;
            if (validd2 !== ((4 - k) >= 2))
                $display("FAIL partial_validd2[%0d] got=%b required=%b", k, validd2, (4 - k) >= 2);
            else passed++;
            tick();
        end
        issue_req = 2'd0;
        total++;
        if (validd !== 1'b0 || count !== 4'd0)
            $display("FAIL partial_empty got validd=%b count=%0d required 0/0", validd, count);
        else passed++;
        // Empty queue ignores issue requests
        issue_req = 2'd3;
        tick();
        issue_req = 2'd0;
        total++;
        if (count !== 4'd0) $display("FAIL empty_issue got=%0d required=0", count);
        else passed++;
    endtask

    task automatic test_fill;
        idle();
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + 32'(8 * i));
            tick();
            if (i == 2) begin
                total++;
                if (count !== 4'd6 || stallf !== 1'b0)
                    $display("FAIL fill_six got count=%0d stallf=%b required 6/0", count, stallf);
                else passed++;
            end
        end
        total++;
        if (count !== 4'd8 || stallf !== 1'b1)
            $display("FAIL fill_full got count=%0d stallf=%b required 8/1", count, stallf);
        else passed++;
        push(32'h300);
        tick();
        total++;
        if (count !== 4'd8) $display("FAIL fill_ignored got=%0d required=8", count);
        else passed++;
        fetch_valid = 1'b0;
        issue_req   = 2'd2;
        tick();
        total++;
        if (count !== 4'd6 || stallf !== 1'b0 || pcd !== 32'h208)
            $display("FAIL fill_relief got count=%0d stallf=%b pcd=%h required 6/0/208", count, stallf, pcd);
        else passed++;
        tick();
        tick();
        total++;
        if (pcd !== 32'h218 || pcd2 !== 32'h21C || count !== 4'd2)
            $display("FAIL fill_tail got pcd=%h pcd2=%h count=%0d required 218/21c/2", pcd, pcd2, count);
        else passed++;
        tick();
        issue_req = 2'd0;
        total++;
        if (count !== 4'd0) $display("FAIL fill_drain got=%0d required=0", count);
        else passed++;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc;
        idle();
        exp_pc    = 32'h400;
        issue_req = 2'd2;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                total++;
                if (pcd !== exp_pc || pcd2 !== exp_pc + 32'd4 || !validd2)
                    $display("FAIL wrap_pc[%0d] got=%h/%h required=%h/%h", c, pcd, pcd2, exp_pc, exp_pc + 32'd4);
                else passed++;
                exp_pc = exp_pc + 32'd8;
            end
            push(32'h400 + 32'(8 * c));
            tick();
            total++;
            if (count !== 4'd2 || stallf !== 1'b0)
                $display("FAIL wrap_count[%0d] got=%0d stallf=%b required 2/0", c, count, stallf);
            else passed++;
        end
        fetch_valid = 1'b0;
        total++;
        if (pcd !== 32'h498) $display("FAIL wrap_last got=%h required=498", pcd);
        else passed++;
        tick();
        issue_req = 2'd0;
        total++;
        if (count !== 4'd0) $display("FAIL wrap_drain got=%0d required=0", count);
        else passed++;
    endtask

    task automatic test_flush;
        idle();
        for (int i = 0; i < 3; i++) begin
            push(32'h600 + 32'(8 * i));
            tick();
        end
        total++;
        if (count !== 4'd6) $display("FAIL flush_pre got=%0d required=6", count);
        else passed++;
        push(32'h700);
        issue_req = 2'd2;
        flush     = 1'b1;
        tick();
        idle();
        total++;
        if (count !== 4'd0 || validd !== 1'b0)
            $display("FAIL flush_clear got count=%0d validd=%b required 0/0", count, validd);
        else passed++;
        tick();
        total++;
        if (count !== 4'd0) $display("FAIL flush_discard got=%0d required=0", count);
        else passed++;
        push(32'h800);
        tick();
        fetch_valid = 1'b0;
        total++;
        if (pcd !== 32'h800 || count !== 4'd2)
            $display("FAIL flush_refill got pcd=%h count=%0d required 800/2", pcd, count);
        else passed++;
    endtask

    task automatic test_reset_flush;
        idle();
        push(32'h900);
        tick();
        push(32'hA00);
        reset     = 1'b1;
        flush     = 1'b1;
        issue_req = 2'd1;
        tick();
        idle();
        total++;
        if (count !== 4'd0 || validd !== 1'b0 || stallf !== 1'b0)
            $display("FAIL reset_flush got count=%0d validd=%b stallf=%b required 0/0/0", count, validd, stallf);
        else passed++;
    endtask

    initial begin
        reset       = 1'b1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        issue_req   = 2'd0;
        instrf      = '0;
        instrf2     = '0;
        pcf         = '0;
        #1;
        test_reset();
        test_single_pair();
        test_partial_issue();
        test_fill();
        test_wrap();
        test_flush();
        test_reset_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Dual-wide instruction buffer between the fetch stage and the two decode lanes.
- Each cycle it accepts the fetched pair (instrf at pcf, instrf2 at pcf+4) and issues up to two oldest instructions in program order to decode.
- Back-pressures fetch via stallf.
- Drops all buffered instructions on a decode-stage redirect (taken branch / jump).

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4
- WIDTH, 32, instruction and PC width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears queue
- fetch_valid  input  1  fetch presents a valid pair this cycle
- instrf  input  WIDTH  older fetched instruction
- instrf2  input  WIDTH  younger fetched instruction
- pcf  input  WIDTH  PC of instrf; instrf2 PC is pcf+4
- flush  input  1  redirect from decode (pcsrcd or pcsrcd2 nonzero); discard contents
- issue_req  input  2  decode lanes ready: 0, 1 or 2 (3 treated as 2)
- instrd  output  WIDTH  head instruction (lane 1)
- pcd  output  WIDTH  PC of instrd
- instrd2  output  WIDTH  head+1 instruction (lane 2)
- pcd2  output  WIDTH  PC of instrd2
- validd  output  1  instrd valid
- validd2  output  1  instrd2 valid
- stallf  output  1  fetch must hold PC (fewer than 2 free entries)
- count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: DEPTH entries of {pc, instr}; head and tail pointers, $clog2(DEPTH) bits, wrap modulo DEPTH; count register tracks occupancy 0..DEPTH.
- Reset (sync): head=tail=count=0; all outputs low (validd=validd2=stallf=0, data outputs 0) the cycle after reset is sampled.
- stallf = (count > DEPTH-2), combinational from registered count. Dequeues in the same cycle do not relieve stallf (conservative, no combinational path from issue_req to stallf).
- Enqueue condition: fetch_valid & ~stallf & ~flush.
  - On enqueue, write entry[tail]={pcf,instrf} and entry[tail+1]={pcf+4,instrf2}; tail += 2.
  - Always 2 entries, never 1.
- Issue count n = min(issue_req clamped to 2, count); head += n.
- Outputs are combinational from storage:
  - validd = (count>=1); instrd/pcd = entry[head].
  - validd2 = (count>=2); instrd2/pcd2 = entry[head+1].
  - Invalid lanes drive 0.
- Latency: a pair enqueued at edge t is visible at decode outputs after edge t (zero-bubble when the queue was empty).
- count_next = count + 2·enq − n. Simultaneous enqueue and issue are both performed.
- Ordering: strict program order; lane 1 is always older than lane 2.
- Flush (sync, priority over enqueue and issue):
  - Next cycle head=tail=count=0, validd=validd2=0.
  - Any fetch pair presented in the flush cycle is discarded.
- Reset has priority over flush; reset mid-operation discards all entries.
- Empty: validd=validd2=0; issue_req ignored.
- Full/near-full: count in {DEPTH-1, DEPTH} gives stallf=1; fetch_valid ignored.
- Overflow/underflow cannot occur; an assertion in the bench checks count <= DEPTH.

Test Plan:
- Reset then idle: reset=1 one cycle → count=0, validd=validd2=0, stallf=0, outputs 0.
- Single pair:
  - Stimulus: fetch_valid=1, pcf=0x100, instrf=0xAAAA0001, instrf2=0xBBBB0002, issue_req=0.
  - Next cycle: validd=validd2=1, pcd=0x100, pcd2=0x104, count=2.
  - Then issue_req=2 → count=0.
- Partial issue ordering:
  - Enqueue pairs at pcf=0x0 and 0x8; issue_req=1 per cycle.
  - pcd sequence must be 0x0, 0x4, 0x8, 0xC.
  - validd2 drops when count=1.
- Fill/backpressure with DEPTH=8:
  - Enqueue 4 pairs with issue_req=0 → count=8, stallf=1.
  - A 5th pair is ignored.
  - issue_req=2 → count=6, stallf=0 next cycle.
- Wrap-around: continuous enqueue plus issue_req=2 for 20 cycles, PCs stepping 0x8 from 0x400. Issued PCs must be contiguous with no gaps or duplicates across pointer wrap.
- Flush:
  - With count=6, assert flush together with fetch_valid=1 and issue_req=2.
  - Next cycle count=0, validd=0, and the flush-cycle pair is not present.
  - Reset asserted with flush also yields count=0.
